// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer: funct3/funct7 values,
// FSM states and datapath step modes.
package muldiv_seq_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

endpackage

// File: rtl/muldiv_seq_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring
// shift-subtract divide over an {acc, part} register pair.
module muldiv_step
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  mode_e           mode_i,
  input  logic [XLEN:0]   acc_i,
  input  logic [XLEN-1:0] part_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN:0]   acc_o,
  output logic [XLEN-1:0] part_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum     = acc_i + (part_i[0] ? {1'b0, opnd_i} : '0);
    shifted = {acc_i[XLEN-1:0], part_i[XLEN-1]};
    diff    = shifted - {1'b0, opnd_i};
    acc_o   = acc_i;
    part_o  = part_i;
    if (mode_i == MODE_MUL) begin
      // Multiplier bits retire out of part as product bits shift in from the top.
      acc_o  = {1'b0, sum[XLEN:1]};
      part_o = {sum[0], part_i[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      acc_o  = diff;
      part_o = {part_i[XLEN-2:0], 1'b1};
    end else begin
      acc_o  = shifted;
      part_o = {part_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M iterative multiply/divide sequencer: valid/ready front and back,
// XLEN-cycle shared datapath, sign fix-up and registered result.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEFAULT,
  parameter bit          FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN:0]     acc_q, acc_d;
  logic [XLEN-1:0]   part_q, part_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic              is_div, b_zero, ovf, special;
  logic [XLEN-1:0]   special_res;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;
  logic [XLEN:0]     step_acc;
  logic [XLEN-1:0]   step_part;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .mode_i (op_q[2] ? MODE_DIV : MODE_MUL),
    .acc_i  (acc_q),
    .part_i (part_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc),
    .part_o (step_part)
  );

  // Operand conditioning and special-case detection at accept.
  always_comb begin
    a_signed    = funct3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    b_signed    = funct3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    a_neg       = a_signed & rs1[XLEN-1];
    b_neg       = b_signed & rs2[XLEN-1];
    a_abs       = a_neg ? -rs1 : rs1;
    b_abs       = b_neg ? -rs2 : rs2;
    is_div      = funct3[2];
    b_zero      = (rs2 == '0);
    ovf         = (funct3 inside {F3_DIV, F3_REM}) && (rs1 == INT_MIN) && (rs2 == '1);
    special     = FAST_SPECIAL && is_div && (b_zero || ovf);
    special_res = b_zero ? (funct3[1] ? rs1 : '1) : (funct3[1] ? '0 : INT_MIN);
  end

  // Sign correction and result selection applied in FIX.
  always_comb begin
    prod   = {acc_q[XLEN-1:0], part_q};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -part_q : part_q;
    rem_s  = neg_rem_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    unique case (op_q)
      F3_MUL:                       fix_res = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_res = quo_s;
      default:                      fix_res = rem_s;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    part_d    = part_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          op_d      = funct3;
          acc_d     = '0;
          part_d    = is_div ? a_abs : b_abs;
          opnd_d    = is_div ? b_abs : a_abs;
          // A zero divisor keeps an unsigned all-ones quotient regardless of signs.
          neg_d     = (a_neg ^ b_neg) & ~(is_div & b_zero);
          neg_rem_d = a_neg;
          cnt_d     = CNT_W'(XLEN - 1);
          if (special) begin
            result_d = special_res;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d  = step_acc;
        part_d = step_part;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = ST_FIX;
      end
      ST_FIX: begin
        result_d = fix_res;
        state_d  = ST_DONE;
      end
      default: begin
        if (out_ready) state_d = ST_IDLE;
      end
    endcase
    if (flush && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      part_q    <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      part_q    <= part_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) & ~flush;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32M cases, handshake/flush/reset
// scenarios and randomized operations against a 64-bit arithmetic reference.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1, rs2, result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .rs1       (rs1),
    .rs2       (rs2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, pu;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (f3)
      3'b000: begin p = sa * sb; r = p[31:0]; end
      3'b001: begin p = sa * sb; r = p[63:32]; end
      3'b010: begin p = sa * longint'(ub); r = p[63:32]; end
      3'b011: begin pu = ua * ub; r = pu[63:32]; end
      3'b100: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'b101: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin pu = ua / ub; r = pu[31:0]; end
      end
      3'b110: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else begin pu = ua % ub; r = pu[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f3[2] && (b == 0 || ((f3 == 3'b100 || f3 == 3'b110) &&
                             a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return XLEN + 2;
  endfunction

  // Caller is just past a negedge; returns just past the negedge after the handshake.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat_exp,
                        input int hold);
    int lat;
    funct3 = f3; rs1 = a; rs2 = b; in_valid = 1'b1; out_ready = 1'b0;
    #1 check_eq({tag, ".in_ready"}, in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0; rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    check_eq({tag, ".latency"}, lat, lat_exp);
    check_eq({tag, ".result"}, result, exp);
    repeat (hold) begin
      @(negedge clk);
      check_eq({tag, ".hold_valid"}, out_valid, 1);
      check_eq({tag, ".hold_result"}, result, exp);
      check_eq({tag, ".hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, ".idle_busy"}, busy, 0);
    check_eq({tag, ".idle_valid"}, out_valid, 0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          seen;

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    funct3 = '0; rs1 = '0; rs2 = '0;
    #12;
    check_eq("rst.in_ready", in_ready, 1);
    check_eq("rst.out_valid", out_valid, 0);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul",     3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
    run_op("mulhu",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
    run_op("mulh",    3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34, 0);
    run_op("mulhsu",  3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34, 0);
    run_op("div",     3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, 0);
    run_op("rem",     3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, 0);
    run_op("divu",    3'b101, 32'd100,        32'd7,         32'd14,        34, 0);
    run_op("remu",    3'b111, 32'd100,        32'd7,         32'd2,         34, 0);
    run_op("divu0",   3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  0);
    run_op("rem0",    3'b110, 32'd5,          32'd0,         32'd5,         1,  0);
    run_op("div_ovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
    run_op("rem_ovf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  0);
    run_op("div_neg0", 3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1,  0);

    // Stall in DONE, then back-to-back accept on the edge after the handshake.
    run_op("hold",    3'b000, 32'd1234,       32'd5678,      32'd7006652,   34, 10);
    run_op("b2b",     3'b101, 32'd50,         32'd5,         32'd10,        34, 0);

    // Flush mid-CALC discards the operation.
    funct3 = 3'b100; rs1 = 32'd1000; rs2 = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (12) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check_eq("flush.busy", busy, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("flush.no_valid", seen, 0);
    run_op("post_flush", 3'b101, 32'd9, 32'd3, 32'd3, 34, 0);

    // Flush in IDLE blocks the request.
    funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd3; in_valid = 1'b1; flush = 1'b1;
    #1 check_eq("idle_flush.in_ready", in_ready, 0);
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_eq("idle_flush.busy", busy, 0);

    // Asynchronous reset mid-CALC.
    funct3 = 3'b000; rs1 = 32'd11; rs2 = 32'd13; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("arst.busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst.busy", busy, 0);
    check_eq("arst.out_valid", out_valid, 0);
    check_eq("arst.in_ready", in_ready, 1);
    check_eq("arst.result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'h0;
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), f3, a, b, ref_model(f3, a, b), exp_latency(f3, a, b),
             int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative sequencer for the RV32M multiply/divide operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the single-cycle ALU in the execute stage. Decode steers opcode 0110011 with funct7 = 0000001 here, not to the ALU.
- Owns one shared shift/add-subtract datapath and sequences it over XLEN cycles.
- Stalls the pipeline through a valid/ready handshake on both sides.

Parameters:
- XLEN, 32, operand and result width; iteration count = XLEN.
- FAST_SPECIAL, 1, when 1, divide-by-zero and signed overflow bypass iteration.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request.
- funct3  in  3  RV32M operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  in  XLEN  operand A (multiplicand / dividend).
- rs2  in  XLEN  operand B (multiplier / divisor).
- flush  in  1  abort the in-flight operation (branch mispredict / trap).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  result, valid only while out_valid = 1.
- busy  out  1  high in any state other than IDLE; drives the pipeline stall.

Behaviour:
- Reset: clk and rst_n only; polarity and synchronicity fixed as above. While rst_n = 0, asynchronously:
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - result = 0; all internal registers = 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid at edge t, latch funct3 and both operands.
  - Signed ops take absolute values of the signed operands and record the result sign.
  - Load the iteration counter with XLEN-1 and go to CALC.
- Special cases (FAST_SPECIAL = 1), checked at accept; go straight to DONE, out_valid high from cycle t+1:
  - rs2 = 0: DIV/DIVU give all ones; REM/REMU give rs1.
  - DIV with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF gives 0x80000000; REM in the same case gives 0.
  - With FAST_SPECIAL = 0 these run the full iteration and must still produce the same results.
- CALC, one datapath step per cycle, counter decrements:
  - Multiply: shift-add producing a 2*XLEN product.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - Leave CALC when the counter reaches 0, after exactly XLEN cycles (t+1 .. t+XLEN).
- FIX, cycle t+XLEN+1:
  - Apply sign correction: quotient negated if operand signs differ; remainder takes the dividend's sign; product negated if the result sign is negative.
  - Select the low half (MUL), high half (MULH*), quotient or remainder into result.
- DONE:
  - out_valid = 1 from cycle t+XLEN+2; in_ready = 0.
  - result stays stable until out_valid & out_ready, then go to IDLE.
  - Back-to-back: a new request is accepted no earlier than the cycle after the handshake (no same-cycle DONE->accept).
- Latency: XLEN+2 cycles from accept edge to out_valid (34 for XLEN=32); 1 cycle for special cases.
- flush:
  - In CALC, FIX or DONE: go to IDLE next edge, out_valid = 0, result discarded.
  - In IDLE together with in_valid: flush wins and the request is not accepted.
- Widths: MULHSU treats rs1 as signed and rs2 as unsigned. All arithmetic is internally XLEN+1 bits for the divide remainder and 2*XLEN bits for the product.
- busy = (state != IDLE); in_ready = (state == IDLE) & ~flush.
- in_valid outside IDLE is ignored; operands are not re-sampled.

Decomposition:
- Shared header MulDiv.vh, included alongside Opcode.vh and ALUop.vh:
  - funct3 encodings for the eight RV32M ops and the funct7 value 0000001.
  - State encodings IDLE/CALC/FIX/DONE.
- Sub-module muldiv_step, combinational, one iteration:
  - Inputs: mode (mul/div), accumulator, operand.
  - Outputs: next accumulator and next partial result.
- muldiv_seq holds the FSM, counter, sign bookkeeping and output register.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB; out_valid exactly 34 cycles after accept. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0. Each has out_valid 1 cycle after accept.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and result stable, in_ready=0. Then out_ready=1 -> IDLE next cycle; new request accepted on the following edge.
- Assert flush at CALC cycle 12 -> busy=0 next cycle, no out_valid. A following DIVU 9/3 returns 3. Also assert rst_n=0 mid-CALC -> outputs take reset values immediately, without waiting for clk.
